// File: rtl/sm4_round_sequencer.sv
// Iterative SM4 engine: one key expansion into a round-key file, then ROUNDS_PER_CYCLE rounds per clock on each block.
// Latency: out_valid NR = 32/ROUNDS_PER_CYCLE edges after block accept. Backpressure: result held in DONE until out_ready.
// Optional SM4_ZEROIZE_EN adds a synchronous i_zeroize that wipes the key file and aborts any operation in flight.
module sm4_round_sequencer #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
`ifdef SM4_ZEROIZE_EN
    input  logic         i_zeroize,
`endif
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [127:0] i_key,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_in_mode,
    input  logic [127:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data,
    output logic         o_key_loaded,
    output logic         o_busy
);

    localparam int NR = 32 / ROUNDS_PER_CYCLE;
    localparam int SH = $clog2(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST = 5'(NR - 1);
    localparam logic [31:0] FK [0:3] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
            $error("sm4_round_sequencer: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    function automatic logic [31:0] f_tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] f_t(input logic [31:0] a);
        logic [31:0] b;
        b = f_tau(a);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [31:0] f_tp(input logic [31:0] a);
        logic [31:0] b;
        b = f_tau(a);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK byte j of constant i is (4i+j)*7 mod 256
    function automatic logic [31:0] f_ck(input logic [4:0] i);
        logic [31:0] v;
        logic [7:0]  b;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            b = (8'({i, 2'b00}) + 8'(j)) * 8'd7;
            v = {v[23:0], b};
        end
        return v;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_KEYED, S_CRYPT, S_DONE} state_t;

    state_t         r_state;
    logic [4:0]     r_cnt;
    logic [31:0]    r_k [0:3];
    logic [31:0]    r_x [0:3];
    logic           r_mode;
    logic           r_out_valid;
    logic [127:0]   r_out_data;
    logic           r_key_loaded;
    logic           r_busy;
    logic [31:0]    r_rk [0:31];

    logic           w_zeroize;
    logic           w_key_hs;
    logic           w_in_hs;
    logic [4:0]     w_base;
    logic [31:0]    w_knext [0:3];
    logic [31:0]    w_xnext [0:3];
    logic [31:0]    w_rkw   [0:ROUNDS_PER_CYCLE-1];
    logic [4:0]     w_rkidx [0:ROUNDS_PER_CYCLE-1];

`ifdef SM4_ZEROIZE_EN
    assign w_zeroize = i_zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign o_key_ready  = ~w_zeroize & ((r_state == S_IDLE) | (r_state == S_KEYED));
    assign o_in_ready   = ~w_zeroize & (r_state == S_KEYED) & ~i_key_valid;
    assign w_key_hs     = i_key_valid & o_key_ready;
    assign w_in_hs      = i_in_valid & o_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_key_loaded = r_key_loaded;
    assign o_busy       = r_busy;
    assign w_base       = r_cnt << SH;

    // Shared sliding windows: key schedule uses T', data path uses T.
    always_comb begin : p_rounds
        logic [31:0] kw [0:ROUNDS_PER_CYCLE+3];
        logic [31:0] xw [0:ROUNDS_PER_CYCLE+3];
        logic [4:0]  idx;
        logic [4:0]  rsel;
        for (int i = 0; i < 4; i++) begin
            kw[i] = r_k[i];
            xw[i] = r_x[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx        = w_base | 5'(j);
            rsel       = r_mode ? idx : ~idx;
            kw[j+4]    = kw[j] ^ f_tp(kw[j+1] ^ kw[j+2] ^ kw[j+3] ^ f_ck(idx));
            xw[j+4]    = xw[j] ^ f_t(xw[j+1] ^ xw[j+2] ^ xw[j+3] ^ r_rk[rsel]);
            w_rkw[j]   = kw[j+4];
            w_rkidx[j] = idx;
        end
        for (int i = 0; i < 4; i++) begin
            w_knext[i] = kw[ROUNDS_PER_CYCLE+i];
            w_xnext[i] = xw[ROUNDS_PER_CYCLE+i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_zeroize) begin
            for (int i = 0; i < 32; i++) r_rk[i] <= '0;
        end else if (r_state == S_KEYEXP) begin
            for (int j = 0; j < ROUNDS_PER_CYCLE; j++) r_rk[w_rkidx[j]] <= w_rkw[j];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_key_loaded <= 1'b0;
            r_busy       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_k[i] <= '0;
                r_x[i] <= '0;
            end
        end else if (w_zeroize) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_key_loaded <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_KEYED: begin
                    if (w_key_hs) begin
                        for (int i = 0; i < 4; i++) r_k[i] <= i_key[127-32*i -: 32] ^ FK[i];
                        r_cnt        <= '0;
                        r_key_loaded <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_KEYEXP;
                    end else if (w_in_hs) begin
                        for (int i = 0; i < 4; i++) r_x[i] <= i_in_data[127-32*i -: 32];
                        r_mode  <= i_in_mode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CRYPT;
                    end
                end
                S_KEYEXP: begin
                    r_k <= w_knext;
                    if (r_cnt == LAST) begin
                        r_cnt        <= '0;
                        r_key_loaded <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_KEYED;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_CRYPT: begin
                    r_x <= w_xnext;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_out_data  <= {w_xnext[3], w_xnext[2], w_xnext[1], w_xnext[0]};
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_KEYED;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
